// File: rtl/cpuclk_sync_gen.sv
// cpuclk_sync_gen: glitch-free CPU clock switching between synchronised BBC phi0 and a divided hsclk
module cpuclk_sync_gen (
    input  logic       hsclk,
    input  logic       rst,
    input  logic       lsclk_in,
    input  logic       hsclk_sel,
    input  logic [1:0] hsclk_div_sel,
    input  logic [1:0] cpuclk_div_sel,
    output logic       clkout,
    output logic       hsclk_selected
);
    typedef enum logic [1:0] {LS, HS, WAIT_LS} state_t;
    state_t     state, state_nx;
    logic       ls_s1, ls_s2, ls_s3, ls_fall, clk_nx;
    logic [2:0] cnt, cnt_nx, n_r, n_nx, low_len;
    logic [1:0] s_r, s_nx;
    assign ls_fall = !ls_s2 & ls_s3;
    assign low_len = {1'b0, hsclk_div_sel} + {1'b0, cpuclk_div_sel};
    always_comb begin
        state_nx = state;
        clk_nx   = clkout;
        cnt_nx   = cnt;
        n_nx     = n_r;
        s_nx     = s_r;
        case (state)
            LS: begin
                clk_nx = ls_s2;
                if (ls_fall && hsclk_sel) begin
                    state_nx = HS;
                    clk_nx   = 1'b0;
                    cnt_nx   = low_len;
                    n_nx     = {1'b0, hsclk_div_sel} + 3'd1;
                    s_nx     = cpuclk_div_sel;
                end
            end
            HS: begin
                if (cnt != 3'd0) begin
                    cnt_nx = cnt - 3'd1;
                end else if (!clkout) begin
                    clk_nx = 1'b1;
                    cnt_nx = n_r - 3'd1;
                end else if (!hsclk_sel) begin
                    state_nx = WAIT_LS;
                    clk_nx   = 1'b0;
                end else begin
                    clk_nx = 1'b0;
                    cnt_nx = low_len;
                    n_nx   = {1'b0, hsclk_div_sel} + 3'd1;
                    s_nx   = cpuclk_div_sel;
                end
            end
            WAIT_LS: begin
                clk_nx   = 1'b0;
                state_nx = ls_fall ? LS : WAIT_LS;
            end
            default: begin
                state_nx = LS;
                clk_nx   = 1'b0;
            end
        endcase
    end
    always_ff @(posedge hsclk) begin
        if (rst) begin
            state          <= LS;
            clkout         <= 1'b0;
            hsclk_selected <= 1'b0;
            ls_s1          <= 1'b0;
            ls_s2          <= 1'b0;
            ls_s3          <= 1'b0;
            cnt            <= 3'd0;
            n_r            <= 3'd1;
            s_r            <= 2'd0;
        end else begin
            state          <= state_nx;
            clkout         <= clk_nx;
            hsclk_selected <= state_nx == HS;
            ls_s1          <= lsclk_in;
            ls_s2          <= ls_s1;
            ls_s3          <= ls_s2;
            cnt            <= cnt_nx;
            n_r            <= n_nx;
            s_r            <= s_nx;
        end
    end
endmodule

// File: tb/tb_cpuclk_sync_gen.sv
// tb_cpuclk_sync_gen: directed vector table plus multi-cycle sequences for cpuclk_sync_gen
module tb_cpuclk_sync_gen;
    logic       hsclk = 1'b0;
    logic       rst = 1'b1;
    logic       lsclk_in = 1'b0;
    logic       hsclk_sel = 1'b0;
    logic [1:0] hsclk_div_sel = 2'b01;
    logic [1:0] cpuclk_div_sel = 2'b00;
    logic       clkout;
    logic       hsclk_selected;
    int         n_cmp = 0;
    int         n_bad = 0;
    typedef struct {
        logic       rst, ls, sel;
        logic [1:0] div, cpu;
        logic       clk, hss;
    } vec_t;
    vec_t tbl [15];
    cpuclk_sync_gen dut (
        .hsclk(hsclk),
        .rst(rst),
        .lsclk_in(lsclk_in),
        .hsclk_sel(hsclk_sel),
        .hsclk_div_sel(hsclk_div_sel),
        .cpuclk_div_sel(cpuclk_div_sel),
        .clkout(clkout),
        .hsclk_selected(hsclk_selected)
    );
    always #5 hsclk = ~hsclk;
    task automatic cyc();
        @(posedge hsclk);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic wait_val(input logic v);
        int k = 0;
        while (clkout !== v && k < 200) begin
            cyc();
            k++;
        end
        chk("wait_clkout", int'(clkout), int'(v));
    endtask
    task automatic wait_sel();
        int k = 0;
        while (hsclk_selected !== 1'b1 && k < 200) begin
            cyc();
            k++;
        end
        chk("wait_hs_entry", int'(hsclk_selected), 1);
    endtask
    task automatic measure(input string name, input int exp);
        int   len = 0;
        logic v = clkout;
        while (clkout === v && len < 64) begin
            cyc();
            len++;
        end
        chk(name, len, exp);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    initial begin
        logic hist [64];
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1};
        for (int i = 0; i < 15; i++) begin
            rst            = tbl[i].rst;
            lsclk_in       = tbl[i].ls;
            hsclk_sel      = tbl[i].sel;
            hsclk_div_sel  = tbl[i].div;
            cpuclk_div_sel = tbl[i].cpu;
            cyc();
            chk($sformatf("tbl%0d_clkout", i), int'(clkout), int'(tbl[i].clk));
            chk($sformatf("tbl%0d_hs_sel", i), int'(hsclk_selected), int'(tbl[i].hss));
        end
        hsclk_div_sel  = 2'b01;
        cpuclk_div_sel = 2'b11;
        wait_val(1'b1);
        wait_val(1'b0);
        measure("stretch_low_n2s3", 5);
        hsclk_div_sel = 2'b11;
        measure("stretch_high_n2", 2);
        measure("stretch_low_n4s3", 7);
        measure("stretch_high_n4", 4);
        wait_val(1'b1);
        hsclk_sel = 1'b0;
        measure("return_high_completes", 4);
        chk("return_wait_hs_sel", int'(hsclk_selected), 0);
        lsclk_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("wait_ls_held_low", int'(clkout), 0);
            chk("wait_ls_hs_sel", int'(hsclk_selected), 0);
        end
        lsclk_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("wait_ls_low_phi0", int'(clkout), 0);
        end
        lsclk_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("return_tracks_ls", int'(clkout), int'(i >= 2));
        end
        hsclk_div_sel  = 2'b00;
        cpuclk_div_sel = 2'b00;
        hsclk_sel      = 1'b1;
        lsclk_in       = 1'b0;
        wait_sel();
        wait_val(1'b1);
        chk("pre_reset_hs_sel", int'(hsclk_selected), 1);
        rst = 1'b1;
        cyc();
        chk("mid_hs_reset_clkout", int'(clkout), 0);
        chk("mid_hs_reset_hs_sel", int'(hsclk_selected), 0);
        rst       = 1'b0;
        hsclk_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_reset_low", int'(clkout), 0);
        end
        for (int i = 0; i < 64; i++) begin
            hist[i]  = ((i / 16) % 2) == 0;
            lsclk_in = hist[i];
            cyc();
            chk("ls_track_clkout", int'(clkout), i >= 2 ? int'(hist[i-2]) : 0);
            chk("ls_track_hs_sel", int'(hsclk_selected), 0);
        end
        hsclk_sel = 1'b1;
        lsclk_in  = 1'b1;
        repeat (4) cyc();
        lsclk_in = 1'b0;
        wait_sel();
        lsclk_in = 1'b1;
        repeat (4) cyc();
        wait_val(1'b1);
        wait_val(1'b0);
        cyc();
        chk("coin_high", int'(clkout), 1);
        lsclk_in = 1'b0;
        cyc();
        chk("coin_low", int'(clkout), 0);
        chk("coin_still_hs", int'(hsclk_selected), 1);
        hsclk_sel = 1'b0;
        cyc();
        chk("coin_last_high", int'(clkout), 1);
        cyc();
        chk("coin_exit_clkout", int'(clkout), 0);
        chk("coin_exit_hs_sel", int'(hsclk_selected), 0);
        lsclk_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("coin_wait_ls_held", int'(clkout), 0);
        end
        lsclk_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("coin_fall_low", int'(clkout), 0);
        end
        lsclk_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("coin_ls_tracks", int'(clkout), int'(i >= 2));
            chk("coin_ls_hs_sel", int'(hsclk_selected), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpuclk_sync_gen.md
CPUCLK_SYNC_GEN -- requirements
Module: cpuclk_sync_gen

Interface
REQ-001 SHALL have port hsclk, input, 1: sole clock; all flops rising-edge.
REQ-002 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-003 SHALL have port lsclk_in, input, 1: BBC phi0, asynchronous to hsclk; used as data, never as a clock.
REQ-004 SHALL have port hsclk_sel, input, 1: request high-speed CPU clock (1) or BBC-locked clock (0).
REQ-005 SHALL have port hsclk_div_sel, input, 2: HS half-period select, N = value+1 hsclk cycles (1..4).
REQ-006 SHALL have port cpuclk_div_sel, input, 2: HS low-phase stretch S = value hsclk cycles (0..3).
REQ-007 SHALL have port clkout, output, 1: registered CPU clock (phi2 polarity).
REQ-008 SHALL have port hsclk_selected, output, 1: registered, 1 only while in state HS.

Function
REQ-009 SHALL synchronise lsclk_in through flops ls_s1 -> ls_s2 -> ls_s3.
- ls_fall = !ls_s2 & ls_s3.
- ls_s2 is the synchronised phi0.
REQ-010 SHALL implement exactly three states: LS, HS, WAIT_LS.
REQ-011 In LS, clkout SHALL equal ls_s2 delayed one cycle (clkout <= ls_s2 each edge), i.e. 3 hsclk cycles after lsclk_in when setup is met.
REQ-012 LS->HS SHALL occur only on an edge where ls_fall=1 and hsclk_sel=1.
- Next cycle: state HS, clkout=0, low phase begins.
- Low-phase counter loaded with N+S-1.
REQ-013 In LS with hsclk_sel=1 but no ls_fall, SHALL stay LS.
REQ-014 In HS, clkout SHALL alternate phases driven by a 3-bit down-counter cnt.
- Low phase: N+S cycles.
- High phase: N cycles.
- On cnt=0 the phase ends: toggle clkout and reload cnt with next-phase length-1; otherwise decrement.
REQ-015 N and S SHALL be captured into internal registers at the start of each low phase only; divider changes mid-period SHALL NOT alter the current period.
REQ-016 At the end of an HS high phase (clkout=1, cnt=0):
- hsclk_sel=0: state WAIT_LS, clkout=0.
- hsclk_sel=1: start a new low phase.
REQ-017 hsclk_sel SHALL be ignored in HS except at the REQ-016 decision edge.
REQ-018 In WAIT_LS, clkout SHALL be held 0.
- Transition to LS on the edge where ls_fall=1.
- hsclk_sel ignored until LS is reached.
REQ-019 hsclk_selected SHALL be 1 exactly in the cycles where state=HS (registered alongside state).
REQ-020 clkout SHALL never produce a high or low pulse shorter than 1 hsclk cycle.
REQ-021 clkout SHALL never produce a high phase shorter than min(N, one synchronised phi0 high phase).
REQ-022 If ls_fall and the REQ-016 decision coincide, the REQ-016 transition to WAIT_LS SHALL take priority; LS is entered at the next ls_fall, not the same one.

Reset
REQ-023 With rst=1 at an hsclk edge, the following SHALL result:
- state=LS, clkout=0, hsclk_selected=0.
- ls_s1/ls_s2/ls_s3=0, cnt=0.
- N and S registers = 1 and 0.
REQ-024 Reset asserted in any state, including mid HS phase or WAIT_LS, SHALL take effect at the next edge with no extra clkout pulse.
REQ-025 After rst deasserts, SHALL start in LS following lsclk_in.

Verification
REQ-026 LS tracking: lsclk_in square wave, period 32 hsclk, hsclk_sel=0 -> clkout same waveform, 3-cycle lag, hsclk_selected=0 throughout.
REQ-027 Switch to HS: div_sel=01, cpuclk_div_sel=00, raise hsclk_sel -> at first ls_fall clkout low 2 cycles then high 2, repeating; hsclk_selected=1 from entry cycle.
REQ-028 Stretch and mid-period change: in HS with N=2, S=3, write hsclk_div_sel=11 during a high phase -> current period low 5/high 2; next period low 7/high 4.
REQ-029 Return to LS: drop hsclk_sel during a high phase -> high completes, clkout 0 in WAIT_LS until ls_fall, then tracks ls_s2; no pulse under 1 cycle; hsclk_selected=0 from WAIT_LS entry.
REQ-030 Reset mid-HS: assert rst for 1 cycle while clkout=1 -> next edge clkout=0, hsclk_selected=0, state LS.
REQ-031 Coincidence: align ls_fall with the HS decision edge with hsclk_sel=0 -> WAIT_LS entered, LS entered one phi0 period later.
